// File: rtl/board_uart_tx.sv
// Serialises a snapshot of the 16-tile board and score as 8N1 UART bytes: header, 48 tile bytes, 3 score bytes.
// Define BOARD_TX_CHECKSUM_EN to append an XOR checksum byte covering bytes 1..51.
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [319:0] board,
    input  logic [20:0]  score,
    input  logic         send,
    output logic         busy,
    output logic         done,
    output logic         tx
);
`ifdef BOARD_TX_CHECKSUM_EN
    localparam int NBYTES = 53;
`else
    localparam int NBYTES = 52;
`endif
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_reg;
    logic [CW-1:0]   baud_cnt_reg;
    logic [2:0]      bit_idx_reg;
    logic [5:0]      byte_idx_reg;
    logic [319:0]    board_snap_reg;
    logic [20:0]     score_snap_reg;
    logic            tx_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [8*52-1:0] frame_vec;
    logic [7:0]      current_byte;
`ifdef BOARD_TX_CHECKSUM_EN
    logic [7:0]      csum_reg;
    logic [7:0]      next_byte;
`endif

    // Fixed frame layout built from the snapshot: byte k lives at frame_vec[8k +: 8].
    assign frame_vec[7:0] = 8'hA5;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_tile
            assign frame_vec[8*(1+3*gi)   +: 8] = board_snap_reg[20*gi      +: 8];
            assign frame_vec[8*(1+3*gi+1) +: 8] = board_snap_reg[20*gi + 8  +: 8];
            assign frame_vec[8*(1+3*gi+2) +: 8] = {4'b0, board_snap_reg[20*gi + 16 +: 4]};
        end
    endgenerate
    assign frame_vec[8*49 +: 8] = score_snap_reg[7:0];
    assign frame_vec[8*50 +: 8] = score_snap_reg[15:8];
    assign frame_vec[8*51 +: 8] = {3'b0, score_snap_reg[20:16]};

    always_comb begin
        current_byte = 8'h00;
        for (int i = 0; i < 52; i++) begin
            if (byte_idx_reg == 6'(i)) current_byte = frame_vec[8*i +: 8];
        end
`ifdef BOARD_TX_CHECKSUM_EN
        if (byte_idx_reg == 6'd52) current_byte = csum_reg;
`endif
    end

`ifdef BOARD_TX_CHECKSUM_EN
    // Byte about to enter START; zero for the checksum slot so it never folds into itself.
    always_comb begin
        next_byte = 8'h00;
        for (int i = 1; i < 52; i++) begin
            if (byte_idx_reg + 6'd1 == 6'(i)) next_byte = frame_vec[8*i +: 8];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            byte_idx_reg   <= '0;
            board_snap_reg <= '0;
            score_snap_reg <= '0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef BOARD_TX_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (send) begin
                        board_snap_reg <= board;
                        score_snap_reg <= score;
                        byte_idx_reg   <= '0;
                        baud_cnt_reg   <= '0;
`ifdef BOARD_TX_CHECKSUM_EN
                        csum_reg       <= '0;
`endif
                        state_reg      <= START;
                        tx_reg         <= 1'b0;
                        busy_reg       <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt_reg == CNT_MAX) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= current_byte[0];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt_reg == CNT_MAX) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= current_byte[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt_reg == CNT_MAX) begin
                        baud_cnt_reg <= '0;
                        if (byte_idx_reg == LAST_IDX) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            tx_reg    <= 1'b1;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 6'd1;
`ifdef BOARD_TX_CHECKSUM_EN
                            csum_reg     <= csum_reg ^ next_byte;
`endif
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;
endmodule

// File: tb/tb_board_uart_tx.sv
// Bench for board_uart_tx: decodes the serial line with a cycle-sampled UART receiver and compares
// each frame against a byte list computed arithmetically from board/score.
module tb_board_uart_tx;
    localparam int C = 4;
`ifdef BOARD_TX_CHECKSUM_EN
    localparam int NB = 53;
`else
    localparam int NB = 52;
`endif
    localparam int FRAME_CYC = NB * 10 * C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         send = 1'b0;
    logic [319:0] board = '0;
    logic [20:0]  score = '0;
    logic         busy, done, tx;

    board_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .board(board), .score(score),
        .send(send), .busy(busy), .done(done), .tx(tx)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         rx_active = 1'b0;
    int         rx_k = 0;
    logic [7:0] rx_sh = '0;
    int busy_cycles = 0, done_count = 0, done_err = 0, frame_err = 0;
    bit prev_done = 1'b0;

    // Advance one cycle, sampling on the falling edge and running the line receiver.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_k = 0;
            end
        end else begin
            rx_k++;
            for (int j = 0; j < 8; j++)
                if (rx_k == C*(1+j) + C/2) rx_sh[j] = tx;
            if (rx_k == 9*C + C/2) begin
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(rx_sh);
                rx_active = 1'b0;
            end
        end
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin
            done_count++;
            if (prev_done) done_err++;
        end
        prev_done = (done === 1'b1);
    endtask

    task automatic wait_done(input int tgt, output bit ok);
        for (int n = 0; n < 4*FRAME_CYC && done_count < tgt; n++) tick();
        ok = (done_count >= tgt);
    endtask

    // Reference frame: header, each tile as three little-endian bytes, score as three, optional XOR.
    function automatic void build_exp(input logic [319:0] b, input logic [20:0] s);
        int unsigned t;
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            t = 32'(20'(b >> (20*i)));
            exp_q.push_back(8'(t % 256));
            exp_q.push_back(8'((t / 256) % 256));
            exp_q.push_back(8'(t / 65536));
        end
        t = 32'(s);
        exp_q.push_back(8'(t % 256));
        exp_q.push_back(8'((t / 256) % 256));
        exp_q.push_back(8'(t / 65536));
`ifdef BOARD_TX_CHECKSUM_EN
        x = 8'h00;
        for (int k = 1; k < 52; k++) x = x ^ exp_q[k];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endfunction

    function automatic logic [7:0] rx_at(input int k);
        return (k < rx_q.size()) ? rx_q[k] : 8'hxx;
    endfunction

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
        else pass_cnt++;
        // Reset wins over send on the same edge.
        rst = 1'b1;
        send = 1'b1;
        tick();
        rst = 1'b0;
        send = 1'b0;
        chk_cnt++;
        if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL reset_priority: busy=%b tx=%b, required 0/1", busy, tx);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        chk_cnt++;
        if (rx_q.size() != 0 || done_count != 0)
            $display("FAIL reset_no_frame: bytes=%0d dones=%0d, required 0/0", rx_q.size(), done_count);
        else pass_cnt++;
        $display("reset: idle line checked");
    endtask

    // One frame with the current inputs, checked byte-by-byte plus busy length and done count.
    task automatic test_frame(input string name);
        bit ok;
        rx_q.delete();
        busy_cycles = 0;
        done_count = 0;
        build_exp(board, score);
        send = 1'b1;
        tick();
        send = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1 || tx !== 1'b0) $display("FAIL %s_start: busy=%b tx=%b, required 1/0", name, busy, tx);
        else pass_cnt++;
        wait_done(1, ok);
        chk_cnt++;
        if (!ok) $display("FAIL %s_timeout: dones=%0d, required 1", name, done_count);
        else pass_cnt++;
        for (int i = 0; i < 2*C; i++) tick();
        chk_cnt++;
        if (rx_q.size() != NB) $display("FAIL %s_len: got %0d bytes, required %0d", name, rx_q.size(), NB);
        else pass_cnt++;
        for (int k = 0; k < NB; k++) begin
            chk_cnt++;
            if (rx_at(k) !== exp_q[k]) $display("FAIL %s_byte%0d: got %02h, required %02h", name, k, rx_at(k), exp_q[k]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (busy_cycles != FRAME_CYC || done_count != 1)
            $display("FAIL %s_busy: busy=%0d dones=%0d, required %0d/1", name, busy_cycles, done_count, FRAME_CYC);
        else pass_cnt++;
        $display("frame %s: %0d bytes, busy %0d cycles, last byte %02h", name, rx_q.size(), busy_cycles, rx_at(NB-1));
    endtask

    task automatic test_single();
        board = '0;
        board[19:0] = 20'h00002;
        score = 21'd4;
        test_frame("single");
    endtask

    task automatic test_tile15();
        board = '0;
        board[319:300] = 20'h80000;
        score = 21'h1ABCDE;
        test_frame("tile15");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 10; w++) board[32*w +: 32] = $urandom();
            score = 21'($urandom());
            test_frame("random");
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        rx_q.delete();
        done_count = 0;
        board = '0;
        board[19:0] = 20'h00002;
        score = '0;
        build_exp(board, score);
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        for (int i = 0; i < 16; i++) board[20*i +: 20] = 20'h00004;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_done(1, ok);
        for (int i = 0; i < 80; i++) tick();
        chk_cnt++;
        if (!ok || done_count != 1 || busy !== 1'b0)
            $display("FAIL snap_dones: dones=%0d busy=%b, required 1/0", done_count, busy);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() != NB) $display("FAIL snap_len: got %0d bytes, required %0d", rx_q.size(), NB);
        else pass_cnt++;
        for (int k = 0; k < NB; k++) begin
            chk_cnt++;
            if (rx_at(k) !== exp_q[k]) $display("FAIL snap_byte%0d: got %02h, required %02h", k, rx_at(k), exp_q[k]);
            else pass_cnt++;
        end
        $display("frame snapshot: %0d bytes, tile0 byte %02h, dones %0d", rx_q.size(), rx_at(1), done_count);
    endtask

    task automatic test_reset_mid();
        int n;
        rx_q.delete();
        done_count = 0;
        for (int w = 0; w < 10; w++) board[32*w +: 32] = $urandom();
        score = 21'($urandom());
        send = 1'b1;
        tick();
        send = 1'b0;
        for (n = 0; n < FRAME_CYC && rx_q.size() < 10; n++) tick();
        for (int i = 0; i < 3*C; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++;
        if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_abort: tx=%b busy=%b, required 1/0", tx, busy);
        else pass_cnt++;
        for (int i = 0; i < 60; i++) tick();
        chk_cnt++;
        if (done_count != 0 || rx_q.size() != 10)
            $display("FAIL midrst_quiet: dones=%0d bytes=%0d, required 0/10", done_count, rx_q.size());
        else pass_cnt++;
        $display("reset mid-frame: aborted after %0d bytes", rx_q.size());
        test_frame("after_rst");
    endtask

    task automatic test_back_to_back();
        bit ok;
        rx_q.delete();
        done_count = 0;
        for (int w = 0; w < 10; w++) board[32*w +: 32] = $urandom();
        score = 21'($urandom());
        build_exp(board, score);
        send = 1'b1;
        wait_done(1, ok);
        tick();
        chk_cnt++;
        if (!ok || tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_gap: tx=%b busy=%b after done, required 0/1", tx, busy);
        else pass_cnt++;
        send = 1'b0;
        wait_done(2, ok);
        for (int i = 0; i < 80; i++) tick();
        chk_cnt++;
        if (!ok || done_count != 2 || rx_q.size() != 2*NB)
            $display("FAIL b2b_count: dones=%0d bytes=%0d, required 2/%0d", done_count, rx_q.size(), 2*NB);
        else pass_cnt++;
        for (int k = 0; k < NB; k++) begin
            chk_cnt++;
            if (rx_at(k) !== exp_q[k] || rx_at(NB+k) !== exp_q[k])
                $display("FAIL b2b_byte%0d: got %02h/%02h, required %02h", k, rx_at(k), rx_at(NB+k), exp_q[k]);
            else pass_cnt++;
        end
        $display("back-to-back: %0d frames, %0d bytes", done_count, rx_q.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_tile15();
        test_random();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        chk_cnt++;
        if (done_err != 0 || frame_err != 0)
            $display("FAIL line_integrity: long done pulses=%0d stop errors=%0d, required 0/0", done_err, frame_err);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/board_uart_tx.md
# board_uart_tx

Serialises the game state produced by the game controller (16-tile board plus score) into a framed byte stream on a UART 8N1 line. Sits between the game controller's board/score outputs and the FPGA TX pin. It is the transmit end of the host link used by the display/AI side. On a send request it snapshots the state, so the controller may keep updating the board while the frame is on the wire.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- board  in  320  16 tiles × 20 bits; tile i = board[20*i+19 : 20*i], tile 0 = board[19:0].
- score  in  21  current score.
- send  in  1  request a frame; sampled every cycle.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when the final stop bit completes.
- tx  out  1  UART line; idle high.

## Operation
- Frame bytes, in order:
  - Byte 0: header 0xA5.
  - Bytes 1–48: tiles 0..15, 3 bytes each, little-endian. Tile i gives bytes {tile[7:0], tile[15:8], {4'b0, tile[19:16]}}.
  - Bytes 49–51: score, little-endian. The top byte is {3'b0, score[20:16]}.
  - Byte 52: checksum, present only with the macro enabled (see Configuration).
- Each byte is sent as 8N1: start bit 0, data LSB first, stop bit 1.
- States:
  - IDLE: tx=1, busy=0. If send=1, capture board and score into snapshot registers, clear byte index and checksum, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=current_byte[bit_idx], CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if this was the last byte, go to IDLE and pulse done;
    - otherwise increment the byte index and go to START.
- current_byte is selected combinationally from the snapshot by byte index. The snapshot is never updated mid-frame.
- busy=1 in START, DATA and STOP.
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every bit boundary.

## Timing
- Reset values: tx=1, busy=0, done=0. State=IDLE; all counters, snapshot and checksum are 0.
- Reset has priority over send on the same edge. Reset mid-frame aborts: tx=1 and busy=0 after that edge, no done pulse, and the next frame starts from the header.
- A send accepted at edge N gives busy=1 and tx=0 (start bit) from edge N+1.
- Frame length: NBYTES×10×CLKS_PER_BIT cycles, where NBYTES = 52 (53 with checksum).
- On the edge ending the last stop bit: busy goes 0 and done goes 1 for exactly one cycle.
- send while busy=1 is ignored. It is not queued.
- send during the done cycle (busy=0) is accepted. The next start bit follows immediately, with no idle gap.
- Holding send high continuously produces back-to-back frames.

## Configuration
- BOARD_TX_CHECKSUM_EN defined:
  - appends byte 52, the 8-bit XOR of bytes 1–51 (the header is excluded);
  - the checksum accumulates as each byte enters START;
  - NBYTES = 53.
- Undefined: no checksum logic or register; the frame ends after byte 51 and NBYTES = 52.

## Test plan
All scenarios use CLKS_PER_BIT=4 and decode the serial line with a bench UART receiver.
- Reset held 5 cycles, send=0 → tx=1, busy=0, done=0 throughout; no start bit ever appears.
- board[19:0]=20'h00002, rest 0, score=21'd4, one send pulse →
  - bytes A5, 02, 00, 00, then 45×00, then 04, 00, 00;
  - with the macro: a trailing 06;
  - busy high for 2080 cycles (2120 with the macro), then a single done pulse.
- Tile 15 = 20'h80000, score = 21'h1ABCDE → bytes 46–48 = 00, 00, 08; bytes 49–51 = DE, BC, 1A.
- Snapshot and ignored send:
  - start a frame with tile 0 = 2;
  - at cycle 100, change board to all 20'h00004 and pulse send;
  - frame still carries tile 0 = 02 and all other tiles 00;
  - exactly one done pulse; no second frame.
- Assert rst for 1 cycle during byte 10 →
  - tx=1 and busy=0 on the next cycle, no done pulse;
  - a later send yields a complete frame starting with A5.
- Hold send high for two frames → the second start bit begins on the cycle after the done pulse; the two frames are identical when the inputs are static.
